// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the single-cycle CPU control blocks.
//   step_state_e          : debouncer FSM state encoding (all four codes used)
//   DEBOUNCE_CYCLES_SIM   : short debounce window for simulation builds
//   DEBOUNCE_CYCLES_BOARD : debounce window for the board clock
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } step_state_e;

    localparam int DEBOUNCE_CYCLES_SIM   = 16;
    localparam int DEBOUNCE_CYCLES_BOARD = 500000;

endpackage

// File: rtl/step_debouncer_if.sv
// ---------------------------------------------------------------------------
// step_debouncer_if
// Connects the raw step button and the debounced outputs.
//   BTN_L     : raw pushbutton, 0 = pressed (driven by master)
//   EN_L      : debounced level, 0 = pressed (driven by slave)
//   STEP      : one-cycle pulse per accepted press (driven by slave)
//   PRESS_CNT : wrapping count of accepted presses (driven by slave)
// ---------------------------------------------------------------------------
interface step_debouncer_if;
    logic       BTN_L;
    logic       EN_L;
    logic       STEP;
    logic [7:0] PRESS_CNT;

    modport master (output BTN_L, input EN_L, input STEP, input PRESS_CNT);
    modport slave  (input BTN_L, output EN_L, output STEP, output PRESS_CNT);
endinterface

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for an asynchronous, active-low level input.
// Both flops reset to 1 so a released (high) input looks idle out of reset.
//   CLK : system clock
//   RST : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output (second flop)
// ---------------------------------------------------------------------------
module sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others; blocking here would
    // collapse the two stages into one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_debouncer.sv
// ---------------------------------------------------------------------------
// step_debouncer
// Turns the bouncing single-step pushbutton into a clean debounced level
// EN_L, a one-cycle STEP pulse per accepted press, and a wrapping press
// counter. A level change is accepted only after the synchronized input has
// held the new value for DEBOUNCE_CYCLES consecutive cycles.
//   CLK       : system clock, rising edge
//   RST       : synchronous, active-high reset
//   bus.BTN_L : raw active-low button (input)
//   bus.EN_L  : debounced active-low level (registered)
//   bus.STEP  : press pulse (registered)
//   bus.PRESS_CNT : accepted press count, wraps 255 -> 0 (registered)
// ---------------------------------------------------------------------------
module step_debouncer
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
    input  logic               CLK,
    input  logic               RST,
    step_debouncer_if.slave    bus
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_n;
    step_state_e      state,       state_nxt;
    logic [CNT_W-1:0] cnt,         cnt_nxt;
    logic             en_l_q,      en_l_nxt;
    logic             step_q,      step_nxt;
    logic [7:0]       press_cnt_q, press_cnt_nxt;

    sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (bus.BTN_L),
        .q   (sync_n)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RELEASED;
            cnt         <= '0;
            en_l_q      <= 1'b1;
            step_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            en_l_q      <= en_l_nxt;
            step_q      <= step_nxt;
            press_cnt_q <= press_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a value unassigned, which would infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        step_nxt      = 1'b0;
        press_cnt_nxt = press_cnt_q;

        case (state)
            RELEASED: begin
                if (!sync_n) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_n) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Only this transition announces a press.
                    state_nxt     = PRESSED;
                    cnt_nxt       = '0;
                    step_nxt      = 1'b1;
                    press_cnt_nxt = press_cnt_q + 8'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (sync_n) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_n) begin
                    // Release bounce: back to PRESSED silently.
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase

        // EN_L follows the next state so it changes on the same edge.
        en_l_nxt = !((state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT));
    end

    assign bus.EN_L      = en_l_q;
    assign bus.STEP      = step_q;
    assign bus.PRESS_CNT = press_cnt_q;

endmodule

// File: tb/tb_step_debouncer.sv
// ---------------------------------------------------------------------------
// tb_step_debouncer
// Directed bench for step_debouncer with DEBOUNCE_CYCLES = 4. A run-length
// model predicts the outputs every cycle; directed literals pin key points.
// ---------------------------------------------------------------------------
module tb_step_debouncer;

    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    step_debouncer_if bus ();

    step_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int step_total = 0;
    int en_high_ticks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the button seen through a two-sample delay; the debounced level
    // flips once the delayed input has disagreed with it for N+1 consecutive
    // samples, and a flip to 0 is a press.
    typedef struct {
        bit         h1;
        bit         h2;
        bit         en;
        bit         step;
        int         run;
        logic [7:0] cnt;
    } model_t;

    model_t m = '{h1: 1'b1, h2: 1'b1, en: 1'b1, step: 1'b0, run: 0, cnt: 8'd0};
    bit model_on = 1'b0;

    function automatic model_t model_next(input model_t cur, input bit rst, input bit btn);
        model_t n;
        n      = cur;
        n.step = 1'b0;
        if (rst) begin
            n.h1  = 1'b1;
            n.h2  = 1'b1;
            n.en  = 1'b1;
            n.run = 0;
            n.cnt = 8'd0;
            return n;
        end
        if (cur.h2 != cur.en) begin
            n.run = cur.run + 1;
            if (n.run == N + 1) begin
                n.en  = cur.h2;
                n.run = 0;
                if (!cur.h2) begin
                    n.step = 1'b1;
                    n.cnt  = cur.cnt + 8'd1;
                end
            end
        end else begin
            n.run = 0;
        end
        n.h2 = cur.h1;
        n.h1 = btn;
        return n;
    endfunction

    always @(posedge CLK) begin
        m <= model_next(m, RST, bus.BTN_L);
        if (RST) model_on <= 1'b1;
    end

    always @(negedge CLK) begin
        if (model_on) begin
            check("model_en_l",      bus.EN_L,      m.en);
            check("model_step",      bus.STEP,      m.step);
            check("model_press_cnt", bus.PRESS_CNT, m.cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (bus.STEP === 1'b1) step_total++;
            if (bus.EN_L === 1'b1) en_high_ticks++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap_step;
        int snap_en;

        // Reset
        bus.BTN_L = 1'b1;
        RST       = 1'b1;
        tick(3);
        check("reset_en_l",      bus.EN_L,      1'b1);
        check("reset_step",      bus.STEP,      1'b0);
        check("reset_press_cnt", bus.PRESS_CNT, 8'd0);
        RST = 1'b0;
        tick(2);

        // Clean press: first edge seeing BTN_L low is k, EN_L falls on k+N+2
        bus.BTN_L = 1'b0;
        tick(6);
        check("press_not_yet_en_l", bus.EN_L, 1'b1);
        check("press_not_yet_step", bus.STEP, 1'b0);
        tick(1);
        check("press_en_l",      bus.EN_L,      1'b0);
        check("press_step",      bus.STEP,      1'b1);
        check("press_press_cnt", bus.PRESS_CNT, 8'd1);
        tick(1);
        check("press_step_one_cycle", bus.STEP, 1'b0);
        tick(12);

        // Release: symmetric latency, no STEP
        snap_step = step_total;
        bus.BTN_L = 1'b1;
        tick(6);
        check("release_not_yet_en_l", bus.EN_L, 1'b1 ^ 1'b1);
        tick(1);
        check("release_en_l",      bus.EN_L,      1'b1);
        check("release_press_cnt", bus.PRESS_CNT, 8'd1);
        tick(10);
        check("release_no_step", step_total - snap_step, 0);

        // Bounce reject after a fresh reset
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        snap_step = step_total;
        for (int i = 0; i < 30; i++) begin
            bus.BTN_L = ((i / 2) % 2) == 1;
            tick(1);
        end
        check("bounce_en_l",      bus.EN_L,              1'b1);
        check("bounce_no_step",   step_total - snap_step, 0);
        check("bounce_press_cnt", bus.PRESS_CNT,         8'd0);
        tick(20);
        check("bounce_hold_one_step", step_total - snap_step, 1);
        check("bounce_hold_cnt",      bus.PRESS_CNT,         8'd1);
        check("bounce_hold_en_l",     bus.EN_L,              1'b0);

        // Release bounce while PRESSED
        snap_step = step_total;
        snap_en   = en_high_ticks;
        bus.BTN_L = 1'b1;
        tick(2);
        bus.BTN_L = 1'b0;
        tick(15);
        check("rel_bounce_en_l_low", en_high_ticks - snap_en, 0);
        check("rel_bounce_no_step",  step_total - snap_step,  0);
        check("rel_bounce_cnt",      bus.PRESS_CNT,           8'd1);

        // Reset mid-press with the button still held
        RST = 1'b1;
        tick(1);
        check("midrst_en_l",      bus.EN_L,      1'b1);
        check("midrst_press_cnt", bus.PRESS_CNT, 8'd0);
        check("midrst_step",      bus.STEP,      1'b0);
        RST = 1'b0;
        tick(6);
        check("midrst_not_yet_step", bus.STEP, 1'b0);
        check("midrst_not_yet_en_l", bus.EN_L, 1'b1);
        tick(1);
        check("midrst_step_edge7", bus.STEP,      1'b1);
        check("midrst_en_l_low",   bus.EN_L,      1'b0);
        check("midrst_cnt",        bus.PRESS_CNT, 8'd1);
        bus.BTN_L = 1'b1;
        tick(10);

        // Wrap: 256 clean press/release pairs from a reset count
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        snap_step = step_total;
        for (int i = 0; i < 255; i++) begin
            bus.BTN_L = 1'b0;
            tick(9);
            bus.BTN_L = 1'b1;
            tick(9);
        end
        check("wrap_cnt_255", bus.PRESS_CNT, 8'd255);
        bus.BTN_L = 1'b0;
        tick(9);
        bus.BTN_L = 1'b1;
        tick(9);
        check("wrap_cnt_0",    bus.PRESS_CNT,         8'd0);
        check("wrap_steps",    step_total - snap_step, 256);
        check("wrap_end_en_l", bus.EN_L,              1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
